// File: rtl/player_input_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | player_input_if : button/enable inputs and accepted-press outputs    |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
interface player_input_if;
  logic [3:0] buttons;
  logic       enable;
  logic [1:0] playerNum;
  logic       playerPressed;
  logic       multiPress;

  modport master (
    output buttons,
    output enable,
    input  playerNum,
    input  playerPressed,
    input  multiPress
  );

  modport slave (
    input  buttons,
    input  enable,
    output playerNum,
    output playerPressed,
    output multiPress
  );
endinterface
`default_nettype wire

// File: rtl/player_input.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | player_input : sync + debounce of four buttons, single-press FSM     |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module player_input #(
  parameter int DEBOUNCE_CYCLES = 3
) (
  input  wire logic     clk,
  input  wire logic     reset,
  player_input_if.slave bus
);

  localparam int c_CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);

  logic [3:0] r_sync1;
  logic [3:0] r_sync2;
  logic [3:0] w_db;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= 4'b0000;
      r_sync2 <= 4'b0000;
    end else begin
      r_sync1 <= bus.buttons;
      r_sync2 <= r_sync1;
    end
  end

  for (genvar i = 0; i < 4; i++) begin : g_db
    logic               r_level;
    logic [c_CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_level <= 1'b0;
        r_cnt   <= '0;
      end else if (r_sync2[i] == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == c_CNT_MAX) begin
        r_level <= r_sync2[i];
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + c_CNT_ONE;
      end
    end

    assign w_db[i] = r_level;
  end

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PRESSED = 2'd1,
    S_LOCKOUT = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [1:0] r_player_num;
  logic [1:0] w_player_num_nxt;
  logic       r_pressed;
  logic       w_pressed_nxt;
  logic       r_multi;
  logic       w_multi_nxt;
  logic [1:0] w_index;

  always_comb begin
    w_index = 2'd0;
    case (w_db)
      4'b0010: w_index = 2'd1;
      4'b0100: w_index = 2'd2;
      4'b1000: w_index = 2'd3;
      default: w_index = 2'd0;
    endcase
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_player_num_nxt = r_player_num;
    w_pressed_nxt    = r_pressed;
    w_multi_nxt      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_db != 4'b0000) begin
          if (!bus.enable) begin
            // A button already down when the turn arrives is never accepted.
            w_state_nxt = S_LOCKOUT;
          end else if ($onehot(w_db)) begin
            w_player_num_nxt = w_index;
            w_pressed_nxt    = 1'b1;
            w_state_nxt      = S_PRESSED;
          end else begin
            w_multi_nxt = 1'b1;
            w_state_nxt = S_LOCKOUT;
          end
        end
      end
      S_PRESSED: begin
        if (!w_db[r_player_num]) begin
          w_pressed_nxt = 1'b0;
          w_state_nxt   = (w_db == 4'b0000) ? S_IDLE : S_LOCKOUT;
        end
      end
      S_LOCKOUT: begin
        w_pressed_nxt = 1'b0;
        if (w_db == 4'b0000) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_pressed_nxt = 1'b0;
        w_state_nxt   = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_player_num <= 2'd0;
      r_pressed    <= 1'b0;
      r_multi      <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_player_num <= w_player_num_nxt;
      r_pressed    <= w_pressed_nxt;
      r_multi      <= w_multi_nxt;
    end
  end

  assign bus.playerNum     = r_player_num;
  assign bus.playerPressed = r_pressed;
  assign bus.multiPress    = r_multi;

endmodule
`default_nettype wire

// File: tb/tb_player_input.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_player_input : directed self-checking bench for player_input      |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_player_input;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  int   mp_count;

  player_input_if u_if ();

  player_input #(.DEBOUNCE_CYCLES(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (u_if.multiPress === 1'b1) mp_count++;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    total        = 0;
    bad          = 0;
    mp_count     = 0;
    reset        = 1'b1;
    u_if.buttons = 4'b0000;
    u_if.enable  = 1'b0;
    #1;
    chk("rst_pressed", 32'(u_if.playerPressed), 0);
    chk("rst_num", 32'(u_if.playerNum), 0);
    chk("rst_multi", 32'(u_if.multiPress), 0);
    step(2);
    reset = 1'b0;

    // Single press of bit 2, held 10 cycles
    u_if.enable  = 1'b1;
    u_if.buttons = 4'b0100;
    step(5);
    chk("sp_before_e6", 32'(u_if.playerPressed), 0);
    step(1);
    chk("sp_rise_e6", 32'(u_if.playerPressed), 1);
    chk("sp_num", 32'(u_if.playerNum), 2);
    step(4);
    chk("sp_held", 32'(u_if.playerPressed), 1);
    u_if.buttons = 4'b0000;
    step(5);
    chk("sp_rel_e5", 32'(u_if.playerPressed), 1);
    step(1);
    chk("sp_rel_e6", 32'(u_if.playerPressed), 0);
    chk("sp_num_hold", 32'(u_if.playerNum), 2);
    chk("sp_no_multi", 32'(mp_count), 0);
    step(3);

    // Glitch of two cycles on bit 1
    u_if.buttons = 4'b0010;
    step(2);
    u_if.buttons = 4'b0000;
    for (int k = 0; k < 8; k++) begin
      step(1);
      chk("gl_pressed", 32'(u_if.playerPressed), 0);
    end
    chk("gl_num", 32'(u_if.playerNum), 2);

    // Simultaneous bits 0 and 1
    u_if.buttons = 4'b0011;
    step(5);
    chk("mp_before_e6", 32'(u_if.multiPress), 0);
    step(1);
    chk("mp_pulse_e6", 32'(u_if.multiPress), 1);
    chk("mp_no_press", 32'(u_if.playerPressed), 0);
    step(1);
    chk("mp_pulse_end", 32'(u_if.multiPress), 0);
    step(3);
    u_if.buttons = 4'b0010;
    step(8);
    chk("mp_lockout_hold", 32'(u_if.playerPressed), 0);
    u_if.buttons = 4'b0000;
    step(8);
    chk("mp_count_one", 32'(mp_count), 1);
    chk("mp_num", 32'(u_if.playerNum), 2);

    // Staggered: bit 0 then bit 3 five cycles later
    u_if.buttons = 4'b0001;
    step(5);
    u_if.buttons = 4'b1001;
    step(1);
    chk("st_press", 32'(u_if.playerPressed), 1);
    chk("st_num", 32'(u_if.playerNum), 0);
    step(6);
    chk("st_still_num", 32'(u_if.playerNum), 0);
    u_if.buttons = 4'b1000;
    step(5);
    chk("st_rel_e5", 32'(u_if.playerPressed), 1);
    step(1);
    chk("st_rel_e6", 32'(u_if.playerPressed), 0);
    step(4);
    chk("st_lockout", 32'(u_if.playerPressed), 0);
    chk("st_lockout_num", 32'(u_if.playerNum), 0);
    u_if.buttons = 4'b0000;
    step(8);
    chk("st_after", 32'(u_if.playerPressed), 0);
    chk("st_no_multi", 32'(mp_count), 1);

    // Enable gating: held across the enable rise is never accepted
    u_if.enable  = 1'b0;
    u_if.buttons = 4'b0010;
    step(8);
    chk("en_off", 32'(u_if.playerPressed), 0);
    u_if.enable = 1'b1;
    step(6);
    chk("en_held", 32'(u_if.playerPressed), 0);
    chk("en_held_num", 32'(u_if.playerNum), 0);
    u_if.buttons = 4'b0000;
    step(8);
    u_if.buttons = 4'b0010;
    step(5);
    chk("en_re_e5", 32'(u_if.playerPressed), 0);
    step(1);
    chk("en_re_e6", 32'(u_if.playerPressed), 1);
    chk("en_re_num", 32'(u_if.playerNum), 1);
    u_if.buttons = 4'b0000;
    step(8);
    chk("en_rel", 32'(u_if.playerPressed), 0);
    chk("en_no_multi", 32'(mp_count), 1);

    // Press of bit 3, enable drop mid-press, then async reset
    u_if.buttons = 4'b1000;
    step(6);
    chk("rs_press", 32'(u_if.playerPressed), 1);
    chk("rs_num", 32'(u_if.playerNum), 3);
    u_if.enable = 1'b0;
    step(2);
    chk("rs_en_drop", 32'(u_if.playerPressed), 1);
    #2;
    reset = 1'b1;
    #1;
    chk("rs_async_pressed", 32'(u_if.playerPressed), 0);
    chk("rs_async_num", 32'(u_if.playerNum), 0);
    step(1);
    chk("rs_in_reset", 32'(u_if.playerPressed), 0);
    u_if.enable = 1'b1;
    reset       = 1'b0;
    step(5);
    chk("rs_re_e5", 32'(u_if.playerPressed), 0);
    step(1);
    chk("rs_re_e6", 32'(u_if.playerPressed), 1);
    chk("rs_re_num", 32'(u_if.playerNum), 3);
    u_if.buttons = 4'b0000;
    step(8);
    chk("rs_rel", 32'(u_if.playerPressed), 0);
    chk("rs_no_multi", 32'(mp_count), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
